// File: rtl/norm_cdf_pair.sv
// norm_cdf_pair: computes N(d1) and N(d2), the standard normal CDF, in Q16.16.
// A 17-entry table is sampled every 0.25 and linearly interpolated. The two
// operands are processed one after the other so a single multiplier is shared.
// Handshake: a one-cycle norm_start is accepted only in IDLE and is ignored at
// all other times. busy is high from the cycle after accept through ADJ2. done
// is a one-cycle pulse, and nd1/nd2/sat are valid while done is high.
module norm_cdf_pair #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             norm_start,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [WIDTH-1:0] nd1,
  output logic [WIDTH-1:0] nd2,
  output logic             busy,
  output logic             done,
  output logic             sat,
  output logic [3:0]       dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_PREP1  = 4'd1,
    S_FETCH1 = 4'd2,
    S_MUL1   = 4'd3,
    S_ADJ1   = 4'd4,
    S_PREP2  = 4'd5,
    S_FETCH2 = 4'd6,
    S_MUL2   = 4'd7,
    S_ADJ2   = 4'd8,
    S_DONE   = 4'd9
  } state_t;

  state_t             r_state;
  logic [31:0]        r_d1, r_d2;
  logic               r_neg, r_satx, r_sat1, r_sat2;
  logic [3:0]         r_k;
  logic [13:0]        r_f;
  logic signed [31:0] r_base, r_slope, r_p;
  logic [31:0]        r_nd1, r_nd2;
  logic               r_busy, r_done, r_sat;

  // T[i] = round(N(i/4) * 65536), i = 0..16
  function automatic logic [31:0] cdf_rom(input logic [4:0] i);
    case (i)
      5'd0:    cdf_rom = 32'd32768;
      5'd1:    cdf_rom = 32'd39237;
      5'd2:    cdf_rom = 32'd45316;
      5'd3:    cdf_rom = 32'd50684;
      5'd4:    cdf_rom = 32'd55138;
      5'd5:    cdf_rom = 32'd58612;
      5'd6:    cdf_rom = 32'd61158;
      5'd7:    cdf_rom = 32'd62911;
      5'd8:    cdf_rom = 32'd64045;
      5'd9:    cdf_rom = 32'd64735;
      5'd10:   cdf_rom = 32'd65129;
      5'd11:   cdf_rom = 32'd65341;
      5'd12:   cdf_rom = 32'd65448;
      5'd13:   cdf_rom = 32'd65498;
      5'd14:   cdf_rom = 32'd65521;
      5'd15:   cdf_rom = 32'd65530;
      default: cdf_rom = 32'd65534;
    endcase
  endfunction

  logic [31:0]        w_x, w_abs, w_m;
  logic               w_neg;
  logic [31:0]        w_t0, w_t1;
  logic signed [31:0] w_prod, w_y, w_res;

  // Operand select and magnitude (0x80000000 clamps to 0x7FFFFFFF)
  always_comb begin
    w_x   = (r_state == S_PREP2) ? r_d2 : r_d1;
    w_neg = w_x[31];
    w_abs = w_neg ? (32'd0 - w_x) : w_x;
    w_m   = w_abs[31] ? 32'h7FFF_FFFF : w_abs;
  end

  // Table lookup, shared multiply, and final adjust/reflection
  always_comb begin
    w_t0   = cdf_rom({1'b0, r_k});
    w_t1   = cdf_rom({1'b0, r_k} + 5'd1);
    w_prod = r_slope * $signed({18'd0, r_f});
    w_y    = r_satx ? 32'sh0001_0000 : (r_base + (r_p >>> 14));
    w_res  = r_neg ? (32'sh0001_0000 - w_y) : w_y;
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_d1    <= '0;
      r_d2    <= '0;
      r_neg   <= 1'b0;
      r_satx  <= 1'b0;
      r_sat1  <= 1'b0;
      r_sat2  <= 1'b0;
      r_k     <= '0;
      r_f     <= '0;
      r_base  <= '0;
      r_slope <= '0;
      r_p     <= '0;
      r_nd1   <= '0;
      r_nd2   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_sat   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (norm_start) begin
            r_d1    <= d1;
            r_d2    <= d2;
            r_busy  <= 1'b1;
            r_state <= S_PREP1;
          end
        end
        S_PREP1, S_PREP2: begin
          r_neg   <= w_neg;
          r_satx  <= (w_m >= 32'h0004_0000);
          r_k     <= w_m[17:14];
          r_f     <= w_m[13:0];
          r_state <= (r_state == S_PREP1) ? S_FETCH1 : S_FETCH2;
        end
        S_FETCH1, S_FETCH2: begin
          r_base  <= $signed(w_t0);
          r_slope <= $signed(w_t1 - w_t0);
          r_state <= (r_state == S_FETCH1) ? S_MUL1 : S_MUL2;
        end
        S_MUL1, S_MUL2: begin
          r_p     <= w_prod;
          r_state <= (r_state == S_MUL1) ? S_ADJ1 : S_ADJ2;
        end
        S_ADJ1: begin
          r_nd1   <= w_res;
          r_sat1  <= r_satx;
          r_state <= S_PREP2;
        end
        S_ADJ2: begin
          r_nd2   <= w_res;
          r_sat2  <= r_satx;
          r_busy  <= 1'b0;
          r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_sat   <= r_sat1 | r_sat2;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign nd1       = r_nd1;
  assign nd2       = r_nd2;
  assign busy      = r_busy;
  assign done      = r_done;
  assign sat       = r_sat;
  assign dbg_state = r_state;

endmodule
